change_dispenser: RTL



---
 rtl/automat_pkg.sv | 17 +
 rtl/coin_select.sv | 32 +++
 rtl/change_dispenser.sv | 132 +++++++++++++
 3 files changed

// File: rtl/automat_pkg.sv
// Types and coin values shared between the vending automat and the change dispenser.
package automat_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SELECT  = 3'd1,
    EJECT   = 3'd2,
    RELEASE = 3'd3,
    DONE    = 3'd4,
    FAULT   = 3'd5
  } state_e;

  localparam int unsigned COIN_HI  = 5;
  localparam int unsigned COIN_MID = 2;
  localparam int unsigned COIN_LO  = 1;

endpackage

// File: rtl/coin_select.sv
// Greedy coin picker: largest denomination not exceeding the remaining amount.
module coin_select
  import automat_pkg::*;
#(
  parameter int unsigned W     = 4,
  parameter int unsigned D_HI  = COIN_HI,
  parameter int unsigned D_MID = COIN_MID,
  parameter int unsigned D_LO  = COIN_LO
) (
  input  logic [W-1:0] remaining_i,
  output logic [2:0]   sel_o,
  output logic [W-1:0] denom_o
);

  localparam logic [W-1:0] HI_W  = W'(D_HI);
  localparam logic [W-1:0] MID_W = W'(D_MID);
  localparam logic [W-1:0] LO_W  = W'(D_LO);

  // sel_o is {hi, mid, lo}; LO is the fallback since D_LO is 1
  always_comb begin
    sel_o   = 3'b001;
    denom_o = LO_W;
    if (remaining_i >= HI_W) begin
      sel_o   = 3'b100;
      denom_o = HI_W;
    end else if (remaining_i >= MID_W) begin
      sel_o   = 3'b010;
      denom_o = MID_W;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Pays out a change amount one coin at a time over a 4-phase eject/ack handshake.
//   state   | meaning
//   IDLE    | waiting for a change amount, rest_ready high
//   SELECT  | pick the next coin and register its eject bit
//   EJECT   | eject held, waiting for coin_ack high
//   RELEASE | coin paid, waiting for coin_ack low
//   DONE    | one-cycle completion pulse
//   FAULT   | ack timeout, sticky until clr_fault
module change_dispenser
  import automat_pkg::*;
#(
  parameter int unsigned W       = 4,
  parameter int unsigned D_HI    = COIN_HI,
  parameter int unsigned D_MID   = COIN_MID,
  parameter int unsigned D_LO    = COIN_LO,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rest_valid,
  input  logic [W-1:0] rest,
  output logic         rest_ready,
  input  logic         coin_ack,
  output logic         eject_hi,
  output logic         eject_mid,
  output logic         eject_lo,
  output logic         busy,
  output logic         done,
  output logic         fault,
  input  logic         clr_fault,
  output logic [W-1:0] remaining
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT);

  state_e         state_q, state_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [2:0]     eject_q, eject_d;
  logic [2:0]     sel;
  logic [W-1:0]   denom;

  coin_select #(
    .W     (W),
    .D_HI  (D_HI),
    .D_MID (D_MID),
    .D_LO  (D_LO)
  ) u_coin_select (
    .remaining_i (rem_q),
    .sel_o       (sel),
    .denom_o     (denom)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      timer_q <= '0;
      eject_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      timer_q <= timer_d;
      eject_q <= eject_d;
    end
  end

  // rem_q is stable through EJECT, so denom still matches the coin being ejected
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    timer_d = timer_q;
    eject_d = eject_q;
    case (state_q)
      IDLE: begin
        if (rest_valid) begin
          rem_d   = rest;
          state_d = (rest == '0) ? DONE : SELECT;
        end
      end
      SELECT: begin
        eject_d = sel;
        timer_d = '0;
        state_d = EJECT;
      end
      EJECT: begin
        timer_d = timer_q + 1'b1;
        if (coin_ack) begin
          rem_d   = rem_q - denom;
          eject_d = '0;
          timer_d = '0;
          state_d = RELEASE;
        end else if (timer_q == T_MAX) begin
          eject_d = '0;
          state_d = FAULT;
        end
      end
      RELEASE: begin
        timer_d = timer_q + 1'b1;
        if (!coin_ack) begin
          state_d = (rem_q == '0) ? DONE : SELECT;
        end else if (timer_q == T_MAX) begin
          state_d = FAULT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      FAULT: begin
        if (clr_fault) begin
          rem_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        eject_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign rest_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign fault      = (state_q == FAULT);
  assign eject_hi   = eject_q[2];
  assign eject_mid  = eject_q[1];
  assign eject_lo   = eject_q[0];
  assign remaining  = rem_q;

endmodule
